// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle for muldiv_sequencer (master drives start/op/val1/val2/flush; slave returns busy/stall/done/hi/lo)
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, val1, val2, flush, input busy, stall, done, hi, lo);
  modport slave  (input start, op, val1, val2, flush, output busy, stall, done, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: bit-serial MULT/MULTU/DIV/DIVU unit with HI/LO results; ports clk, rst_n (async active-low), bus (muldiv_if.slave)
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic               dz_q, dz_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sgn, dz;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  assign sgn   = ~bus.op[0];
  assign dz    = bus.op[1] && bus.val2 == '0;
  assign mag_a = (sgn && bus.val1[WIDTH-1]) ? -bus.val1 : bus.val1;
  assign mag_b = (sgn && bus.val2[WIDTH-1]) ? -bus.val2 : bus.val2;
  // Multiply: acc = {partial product, remaining multiplier bits}
  assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  // Divide: acc = {remainder, quotient}; trial subtract on the left-shifted remainder
  assign diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
  // Sign flags are only ever set for signed ops, so they alone drive the fixup
  assign prod  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo   = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem   = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = busy_q | (bus.start & (state_q == IDLE));
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    if (bus.flush) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          op_d    = bus.op;
          neg_a_d = sgn & bus.val1[WIDTH-1];
          neg_b_d = sgn & bus.val2[WIDTH-1];
          dz_d    = dz;
          m_d     = mag_b;
          cnt_d   = '0;
          busy_d  = 1'b1;
          acc_d   = {{WIDTH{1'b0}}, dz ? bus.val1 : mag_a};
          state_d = dz ? FIXUP : CALC;
        end
        CALC: begin
          cnt_d   = cnt_q + 1'b1;
          acc_d   = !op_q[1] ? {sum, acc_q[WIDTH-1:1]} :
                    diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0} :
                    {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          state_d = (cnt_q == CW'(WIDTH - 1)) ? FIXUP : CALC;
        end
        FIXUP: begin
          hi_d    = dz_q ? acc_q[WIDTH-1:0] : op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
          lo_d    = dz_q ? {WIDTH{1'b1}} : op_q[1] ? quo : prod[WIDTH-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer against a plain-arithmetic reference
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  muldiv_if #(.WIDTH(32)) bus();
  muldiv_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int e;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  always @(posedge clk) edge_cnt++;
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, r;
    logic [63:0] p;
    sa = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (o[1] && b == 0) begin
      h = a;
      l = '1;
    end else if (o[1]) begin
      r = sa / sb; p = r; l = p[31:0];
      r = sa % sb; p = r; h = p[31:0];
    end else begin
      r = sa * sb; p = r;
      h = p[63:32];
      l = p[31:0];
    end
  endfunction
  always @(negedge clk) if (bus.done === 1'b1) begin
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_done: got hi=%h lo=%h expected no done (t=%0t)", bus.hi, bus.lo, $time);
    end else begin
      mon_e = exp_q.pop_front();
      cmp("hi", bus.hi, mon_e.hi);
      cmp("lo", bus.lo, mon_e.lo);
      cmp("done_edge", edge_cnt, mon_e.e);
      last_hi = mon_e.hi;
      last_lo = mon_e.lo;
    end
  end
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model(o, a, b, e.hi, e.lo);
    e.e = edge_cnt + 1 + ((o[1] && b == 0) ? 1 : 33);
    exp_q.push_back(e);
    bus.start = 1'b1;
    bus.op = o;
    bus.val1 = a;
    bus.val2 = b;
    #1 cmp("stall_on_start", bus.stall, 1);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_done();
    logic ok;
    int n;
    ok = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy !== 1'b1) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    cmp("done_seen", bus.done, 1);
    cmp("busy_while_running", ok, 1);
    cmp("busy_at_done", bus.busy, 0);
  endtask
  initial begin
    logic [1:0] o;
    logic [31:0] a, b;
    bus.start = 1'b0;
    bus.op = '0;
    bus.val1 = '0;
    bus.val2 = '0;
    bus.flush = 1'b0;
    #12;
    cmp("rst_busy", bus.busy, 0);
    cmp("rst_done", bus.done, 0);
    cmp("rst_hi", bus.hi, 0);
    cmp("rst_lo", bus.lo, 0);
    cmp("rst_stall", bus.stall, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2'b00, 32'hFFFFFFFD, 32'd5);
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b1; bus.op = 2'b01; bus.val1 = 32'hDEADBEEF; bus.val2 = 32'h11111111;
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done();
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done();
    issue(2'b11, 32'd100, 32'd7);
    wait_done();
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done();
    issue(2'b11, 32'h12345678, 32'd0);
    wait_done();
    issue(2'b00, 32'h00001234, 32'h00005678);
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    void'(exp_q.pop_back());
    cmp("flush_busy", bus.busy, 0);
    cmp("flush_hi", bus.hi, last_hi);
    cmp("flush_lo", bus.lo, last_lo);
    repeat (40) @(posedge clk);
    #1 bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.val1 = 32'd3; bus.val2 = 32'd4;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.flush = 1'b0;
    cmp("flush_start_busy", bus.busy, 0);
    repeat (40) @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      issue(o, a, b);
      wait_done();
    end
    issue(2'b00, 32'd77, 32'd99);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    cmp("async_rst_busy", bus.busy, 0);
    cmp("async_rst_done", bus.done, 0);
    cmp("async_rst_hi", bus.hi, 0);
    cmp("async_rst_lo", bus.lo, 0);
    exp_q.delete();
    last_hi = '0;
    last_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    issue(2'b00, 32'd6, 32'd7);
    wait_done();
    repeat (3) @(posedge clk);
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU, placed beside the EXE stage ALU.
- Accepts one operation per start pulse and iterates one bit per clock: shift-add for multiply, restoring division for divide.
- Holds the 64-bit result in HI/LO registers and asserts stall so the pipeline freezes while it is busy.
- A pipeline flush aborts any operation in flight.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation. Sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- val1  in  WIDTH  rs operand (multiplicand / dividend).
- val2  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  synchronous abort.
- busy  out  1  operation in progress.
- stall  out  1  combinational: busy | (start & state==IDLE).
- done  out  1  one-cycle pulse when HI/LO update.
- hi  out  WIDTH  multiply: upper product. Divide: remainder.
- lo  out  WIDTH  multiply: lower product. Divide: quotient.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - Iteration counter and working registers cleared.
- States: IDLE, CALC, FIXUP.
- IDLE:
  - On start=1 and flush=0, latch op, sign flags and operand magnitudes. Signed ops take the two's-complement magnitude of negative operands; unsigned ops use operands as-is. Clear counter; busy=1.
  - Next state: CALC. Exception: DIV/DIVU with val2==0 goes directly to FIXUP (divide-by-zero path).
- CALC:
  - One iteration per clock; counter runs 0..WIDTH-1.
  - Multiply: 2*WIDTH-bit accumulator; add the multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: shift remainder:quotient left; trial-subtract the divisor; if non-negative, keep the difference and set the quotient LSB.
  - On counter==WIDTH-1, go to FIXUP.
- FIXUP (one cycle):
  - Signed multiply with sign(val1)^sign(val2): negate the 64-bit product.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of val1.
  - Divide-by-zero: hi=val1 (as latched), lo={WIDTH{1'b1}}.
  - Write hi/lo; done=1 for exactly one cycle; busy=0; next state IDLE.
- Latency: start sampled at edge E0 → CALC on E1..E32 → FIXUP results and done registered at E33. Divide-by-zero: results and done at E1.
- busy is high from E0 until the edge where done rises; both change on the same edge.
- start while busy: ignored, no queueing.
- Back-to-back: start may be asserted in the cycle done is high (state is IDLE). That start is accepted.
- flush:
  - In any state, at the next edge: state=IDLE, busy=0, done=0, hi/lo unchanged.
  - flush and start in the same IDLE cycle: flush wins and nothing starts.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF wraps to lo=0x80000000, hi=0 with no exception. Results are all modulo 2^WIDTH.
- hi/lo change only in FIXUP and on reset.

Test Plan:
- MULT val1=0xFFFFFFFD (-3), val2=5 → done at E33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high E0..E32; stall high the cycle start is presented.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then DIVU 100/7 started in the done cycle → lo=14, hi=2, done exactly 34 edges after its start.
- DIV -7/2 (0xFFFFFFF9, 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x12345678/0 → done at E1; hi=0x12345678, lo=0xFFFFFFFF; busy high only E0..E0.
- Flush at iteration 10 of a MULT → IDLE next edge; busy=0; done never pulses; hi/lo retain previous values. A start asserted during busy with different operands has no effect on the running result.
- Assert rst=0 asynchronously mid-CALC (between edges) → busy, done, hi, lo go to 0 immediately. After release, a new MULT 6×7 gives lo=42, hi=0.
